// File: rtl/lcd_byte_tx.sv
// ---------------------------------------------------------------------------
// lcd_byte_tx
//
// Sends one byte to an HD44780-style character LCD over its 4-bit bus.
// The upper nibble goes first, then the lower nibble. Each nibble uses a
// setup / enable / hold sequence. A short gap separates the two nibbles,
// and an execution wait follows the lower nibble. After that, `next`
// pulses for one cycle and the block returns to IDLE.
//
// Parameters (all in clk cycles, each must be >= 1):
//   T_SETUP  data/RS stable before LCD_E rises
//   T_EN     LCD_E high time per nibble
//   T_HOLD   data held after LCD_E falls
//   T_GAP    gap between the upper and lower nibble
//   T_WAIT   execution wait after the lower nibble
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-low reset
//   send     in   level request; SF_D/rs_in are sampled only in IDLE
//   rs_in    in   register select for the byte (0 command, 1 data)
//   SF_D     in   [7:0] byte to transmit
//   next     out  one-cycle pulse: byte written and wait elapsed
//   busy     out  high whenever the FSM is not IDLE
//   lcd_d    out  [3:0] LCD data nibble
//   LCD_E    out  LCD enable strobe
//   LCD_RS   out  LCD register select
//   LCD_RW   out  LCD read/write, always write (0)
//
// Handshake: a byte is accepted on any rising edge where the FSM is IDLE
// and send=1. While busy=1, send/SF_D/rs_in are ignored. `next` marks the
// last busy cycle. If send is still high in the IDLE cycle that follows,
// the next byte is accepted on that cycle's edge.
// ---------------------------------------------------------------------------
module lcd_byte_tx #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 50,
    parameter int T_WAIT  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic       rs_in,
    input  logic [7:0] SF_D,
    output logic       next,
    output logic       busy,
    output logic [3:0] lcd_d,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    // The counter runs 0..T-1 in each state, so it only needs to hold the
    // largest T minus one.
    localparam int T_MAX_A = (T_SETUP > T_EN)   ? T_SETUP : T_EN;
    localparam int T_MAX_B = (T_HOLD  > T_GAP)  ? T_HOLD  : T_GAP;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_WAIT) ? T_MAX_C : T_WAIT;
    localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_HI_SETUP = 4'd1,
        S_HI_EN    = 4'd2,
        S_HI_HOLD  = 4'd3,
        S_GAP      = 4'd4,
        S_LO_SETUP = 4'd5,
        S_LO_EN    = 4'd6,
        S_LO_HOLD  = 4'd7,
        S_WAIT     = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_limit;
    logic            w_last;

    logic [7:0]      r_byte;
    logic            r_rs;
    logic [7:0]      w_byte_nxt;
    logic            w_rs_nxt;
    logic            w_accept;

    logic            r_next;
    logic            r_busy;
    logic [3:0]      r_lcd_d;
    logic            r_lcd_e;
    logic            r_lcd_rs;
    logic            w_next_nxt;
    logic            w_busy_nxt;
    logic [3:0]      w_lcd_d_nxt;
    logic            w_lcd_e_nxt;
    logic            w_lcd_rs_nxt;

    assign w_accept = (r_state == S_IDLE) && send;

    // Terminal count of the current state. DONE uses 0, so it lasts
    // exactly one cycle.
    always_comb begin
        w_limit = '0;
        case (r_state)
            S_HI_SETUP, S_LO_SETUP: w_limit = CW'(T_SETUP - 1);
            S_HI_EN,    S_LO_EN:    w_limit = CW'(T_EN - 1);
            S_HI_HOLD,  S_LO_HOLD:  w_limit = CW'(T_HOLD - 1);
            S_GAP:                  w_limit = CW'(T_GAP - 1);
            S_WAIT:                 w_limit = CW'(T_WAIT - 1);
            default:                w_limit = '0;
        endcase
    end

    assign w_last = (r_cnt == w_limit);

    // Next-state logic: a strictly linear walk through the states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (send)   w_state_nxt = S_HI_SETUP;
            S_HI_SETUP: if (w_last) w_state_nxt = S_HI_EN;
            S_HI_EN:    if (w_last) w_state_nxt = S_HI_HOLD;
            S_HI_HOLD:  if (w_last) w_state_nxt = S_GAP;
            S_GAP:      if (w_last) w_state_nxt = S_LO_SETUP;
            S_LO_SETUP: if (w_last) w_state_nxt = S_LO_EN;
            S_LO_EN:    if (w_last) w_state_nxt = S_LO_HOLD;
            S_LO_HOLD:  if (w_last) w_state_nxt = S_WAIT;
            S_WAIT:     if (w_last) w_state_nxt = S_DONE;
            S_DONE:                 w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shared counter. It restarts at 0 on every state change and stays at
    // 0 while IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Byte and RS latch. The latch only opens on the accepting edge.
    assign w_byte_nxt = w_accept ? SF_D  : r_byte;
    assign w_rs_nxt   = w_accept ? rs_in : r_rs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte <= 8'h00;
            r_rs   <= 1'b0;
        end else begin
            r_byte <= w_byte_nxt;
            r_rs   <= w_rs_nxt;
        end
    end

    // Outputs are decoded from the next state and then registered. Each
    // pin therefore changes on the same edge as the state, and none is
    // driven through decode logic.
    always_comb begin
        w_next_nxt   = 1'b0;
        w_busy_nxt   = 1'b0;
        w_lcd_d_nxt  = 4'h0;
        w_lcd_e_nxt  = 1'b0;
        w_lcd_rs_nxt = 1'b0;
        case (w_state_nxt)
            S_HI_SETUP, S_HI_EN, S_HI_HOLD, S_GAP: begin
                w_lcd_d_nxt = w_byte_nxt[7:4];
            end
            S_LO_SETUP, S_LO_EN, S_LO_HOLD, S_WAIT, S_DONE: begin
                w_lcd_d_nxt = w_byte_nxt[3:0];
            end
            default: begin
                w_lcd_d_nxt = 4'h0;
            end
        endcase
        if (w_state_nxt != S_IDLE) begin
            w_busy_nxt   = 1'b1;
            w_lcd_rs_nxt = w_rs_nxt;
        end
        w_lcd_e_nxt = (w_state_nxt == S_HI_EN) || (w_state_nxt == S_LO_EN);
        w_next_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next   <= 1'b0;
            r_busy   <= 1'b0;
            r_lcd_d  <= 4'h0;
            r_lcd_e  <= 1'b0;
            r_lcd_rs <= 1'b0;
        end else begin
            r_next   <= w_next_nxt;
            r_busy   <= w_busy_nxt;
            r_lcd_d  <= w_lcd_d_nxt;
            r_lcd_e  <= w_lcd_e_nxt;
            r_lcd_rs <= w_lcd_rs_nxt;
        end
    end

    assign next   = r_next;
    assign busy   = r_busy;
    assign lcd_d  = r_lcd_d;
    assign LCD_E  = r_lcd_e;
    assign LCD_RS = r_lcd_rs;
    assign LCD_RW = 1'b0;

endmodule

// File: doc/lcd_byte_tx.md
LCD_BYTE_TX -- requirements
Module: lcd_byte_tx

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, cycles data/RS are stable before LCD_E rises.
REQ-002 SHALL have parameter T_EN, default 12, cycles LCD_E is held high per nibble.
REQ-003 SHALL have parameter T_HOLD, default 1, cycles data is held after LCD_E falls.
REQ-004 SHALL have parameter T_GAP, default 50, cycles between the upper and lower nibble (1 us at 50 MHz).
REQ-005 SHALL have parameter T_WAIT, default 2000, cycles of post-byte execution wait (40 us at 50 MHz).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port send  input  1  level request; byte on SF_D is valid while high.
REQ-009 SHALL have port rs_in  input  1  register select for the byte (0 command, 1 data).
REQ-010 SHALL have port SF_D  input  8  byte to transmit.
REQ-011 SHALL have port next  output  1  one-cycle pulse, byte fully written and wait elapsed.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-013 SHALL have port lcd_d  output  4  LCD data nibble (board SF_D[11:8]).
REQ-014 SHALL have ports LCD_E, LCD_RS, LCD_RW  output  1 each  LCD enable, register select, read/write.

Function
REQ-015 SHALL implement states IDLE, HI_SETUP, HI_EN, HI_HOLD, GAP, LO_SETUP, LO_EN, LO_HOLD, WAIT, DONE, traversed strictly in that order.
REQ-016 SHALL, in IDLE with send=1 at a rising edge (accepting edge), latch SF_D and rs_in and enter HI_SETUP; send=0 keeps IDLE.
REQ-017 SHALL ignore send, SF_D and rs_in in every state except IDLE.
REQ-018 SHALL keep HI_SETUP/LO_SETUP for T_SETUP cycles, HI_EN/LO_EN for T_EN, HI_HOLD/LO_HOLD for T_HOLD, GAP for T_GAP, WAIT for T_WAIT, DONE for exactly 1 cycle, then return to IDLE.
REQ-019 SHALL use one shared down/up counter, cleared on every state entry, wide enough for T_WAIT (11 bits at defaults).
REQ-020 SHALL drive lcd_d = latched byte[7:4] in HI_SETUP, HI_EN, HI_HOLD, GAP; byte[3:0] in LO_SETUP, LO_EN, LO_HOLD, WAIT, DONE; 4'b0000 in IDLE.
REQ-021 SHALL drive LCD_E=1 only in HI_EN and LO_EN, with all outputs registered (glitch-free).
REQ-022 SHALL drive LCD_RS = latched rs_in in every non-IDLE state and 0 in IDLE; LCD_RW SHALL be constant 0.
REQ-023 SHALL assert next=1 only in DONE; busy=1 in all states except IDLE, including DONE.
REQ-024 SHALL, at defaults, give: accepting edge = edge 0; LCD_E high after edges 2..13 and 67..78; next high for the single cycle after edge 2080.
REQ-025 SHALL, if send is still high in the cycle after DONE, accept the then-present SF_D/rs_in immediately (back-to-back bytes, no idle gap beyond one IDLE cycle).

Reset
REQ-026 SHALL, on reset=0, asynchronously enter IDLE and clear counter and latched byte, with next=0, busy=0, lcd_d=0, LCD_E=0, LCD_RS=0, LCD_RW=0.
REQ-027 SHALL, on reset asserted mid-transfer (including during LCD_E high), drop LCD_E within the same cycle and never emit next for the aborted byte.
REQ-028 SHALL, after reset release, require a fresh send sample in IDLE before any LCD activity.

Verification
REQ-029 SHALL verify: send=1, rs_in=0, SF_D=8'h28 for one cycle -> lcd_d=4'h2 with LCD_E pulses after edges 2..13, lcd_d=4'h8 with LCD_E after edges 67..78, LCD_RS=0, next pulse after edge 2080.
REQ-030 SHALL verify: rs_in=1, SF_D=8'h41 -> LCD_RS=1 for the whole transfer, nibbles 4'h4 then 4'h1.
REQ-031 SHALL verify: send held high across four bytes 8'h28, 8'h06, 8'h0C, 8'h01 with SF_D advanced on each next -> four transfers in order, each 2081 cycles apart plus one IDLE cycle.
REQ-032 SHALL verify: SF_D/rs_in changed mid-transfer (e.g. at edge 40) -> transmitted nibbles unchanged.
REQ-033 SHALL verify: reset=0 asserted after edge 5 -> LCD_E=0 immediately, busy=0, no next; after release with send=0 outputs stay idle.
